// File: rtl/aes_core_scheduler_if.sv
// Request/response and AES-core operand signals shared by the scheduler (slave
// view) and whatever drives the requesters and the core (master view).
interface aes_core_scheduler_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]      req_valid;
    logic [128*NREQ-1:0]  req_key;
    logic [128*NREQ-1:0]  req_text;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      rsp_valid;
    logic [127:0]         rsp_data;
    logic                 rsp_err;
    logic                 busy;
    logic [127:0]         aes_key;
    logic [127:0]         aes_plaintext;
    logic                 start;
    logic                 DONE;
    logic [127:0]         aes_ciphertext;

    modport slave (
        input  req_valid, req_key, req_text, DONE, aes_ciphertext,
        output req_ready, rsp_valid, rsp_data, rsp_err, busy,
               aes_key, aes_plaintext, start
    );

    modport master (
        output req_valid, req_key, req_text, DONE, aes_ciphertext,
        input  req_ready, rsp_valid, rsp_data, rsp_err, busy,
               aes_key, aes_plaintext, start
    );
endinterface

// File: rtl/aes_core_scheduler.sv
// Round-robin scheduler sharing one AES-128 core between NREQ requesters, with a
// watchdog that aborts a job whose DONE never arrives.
module aes_core_scheduler #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    aes_core_scheduler_if.slave  bus
);
    localparam int IDXW = $clog2(NREQ);
    localparam int TW   = $clog2(TIMEOUT) + 1;
    localparam logic [TW-1:0]   TLAST  = TW'(TIMEOUT - 1);
    localparam logic [IDXW-1:0] IDXMAX = IDXW'(NREQ - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [IDXW-1:0]    r_ptr;
    logic [IDXW-1:0]    r_grant;
    logic [NREQ-1:0]    r_grant_oh;
    logic [TW-1:0]      r_timer;
    logic [NREQ-1:0]    r_req_ready;
    logic               r_start;
    logic [NREQ-1:0]    r_rsp_valid;
    logic [127:0]       r_rsp_data;
    logic               r_rsp_err;
    logic [127:0]       r_aes_key;
    logic [127:0]       r_aes_plaintext;

    logic               w_found;
    logic [IDXW-1:0]    w_gidx;
    logic [NREQ-1:0]    w_gidx_oh;
    int                 w_scan;
    logic               w_timeout;

    // Search upward from the pointer, wrapping, and take the first pending request.
    always_comb begin
        w_found = 1'b0;
        w_gidx  = r_ptr;
        w_scan  = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_scan = int'(r_ptr) + k;
            if (w_scan >= NREQ) begin
                w_scan = w_scan - NREQ;
            end
            if (!w_found && bus.req_valid[w_scan]) begin
                w_found = 1'b1;
                w_gidx  = IDXW'(w_scan);
            end
        end
    end

    assign w_gidx_oh = {{(NREQ-1){1'b0}}, 1'b1} << w_gidx;
    assign w_timeout = (r_timer == TLAST);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_found) w_state_next = START;
            START:   w_state_next = WAIT;
            WAIT:    if (bus.DONE || w_timeout) w_state_next = RESP;
            RESP:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // All handshake outputs are registered; pulses default low every cycle.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_ptr           <= '0;
            r_grant         <= '0;
            r_grant_oh      <= '0;
            r_timer         <= '0;
            r_req_ready     <= '0;
            r_start         <= 1'b0;
            r_rsp_valid     <= '0;
            r_rsp_data      <= '0;
            r_rsp_err       <= 1'b0;
            r_aes_key       <= '0;
            r_aes_plaintext <= '0;
        end else begin
            r_req_ready <= '0;
            r_start     <= 1'b0;
            r_rsp_valid <= '0;
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_grant         <= w_gidx;
                        r_grant_oh      <= w_gidx_oh;
                        r_aes_key       <= bus.req_key[128*w_gidx +: 128];
                        r_aes_plaintext <= bus.req_text[128*w_gidx +: 128];
                        r_req_ready     <= w_gidx_oh;
                        r_start         <= 1'b1;
                    end
                end
                START: begin
                    r_timer <= '0;
                end
                WAIT: begin
                    r_timer <= r_timer + TW'(1);
                    // DONE takes priority over a watchdog expiry on the same cycle.
                    if (bus.DONE) begin
                        r_rsp_data  <= bus.aes_ciphertext;
                        r_rsp_err   <= 1'b0;
                        r_rsp_valid <= r_grant_oh;
                    end else if (w_timeout) begin
                        r_rsp_data  <= '0;
                        r_rsp_err   <= 1'b1;
                        r_rsp_valid <= r_grant_oh;
                    end
                end
                RESP: begin
                    r_ptr <= (r_grant == IDXMAX) ? '0 : r_grant + 1'b1;
                end
                default: begin
                    r_timer <= '0;
                end
            endcase
        end
    end

    assign bus.req_ready     = r_req_ready;
    assign bus.start         = r_start;
    assign bus.rsp_valid     = r_rsp_valid;
    assign bus.rsp_data      = r_rsp_data;
    assign bus.rsp_err       = r_rsp_err;
    assign bus.aes_key       = r_aes_key;
    assign bus.aes_plaintext = r_aes_plaintext;
    assign bus.busy          = (r_state != IDLE);
endmodule

// File: tb/tb_aes_core_scheduler.sv
// Directed bench for aes_core_scheduler: two instances (watchdog 64 and 8) each
// with a behavioural AES core whose DONE latency is programmable.
module tb_aes_core_scheduler;
    localparam int NREQ = 4;
    localparam logic [127:0] K0 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P0 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic HCLK = 1'b0;
    logic HRESETn;
    int   testsRun = 0;
    int   testsFailed = 0;

    always #5 HCLK = ~HCLK;

    aes_core_scheduler_if #(.NREQ(NREQ)) ifA ();
    aes_core_scheduler_if #(.NREQ(NREQ)) ifB ();

    aes_core_scheduler #(.NREQ(NREQ), .TIMEOUT(64)) dutA (
        .HCLK(HCLK), .HRESETn(HRESETn), .bus(ifA.slave)
    );
    aes_core_scheduler #(.NREQ(NREQ), .TIMEOUT(8)) dutB (
        .HCLK(HCLK), .HRESETn(HRESETn), .bus(ifB.slave)
    );

    // Core stand-in: the known FIPS-197 vector, otherwise key XOR plaintext.
    function automatic logic [127:0] coreModel(input logic [127:0] k, input logic [127:0] p);
        if (k == K0 && p == P0) return C0;
        return k ^ p;
    endfunction

    function automatic logic [127:0] keyOf(input int i);
        return {16{8'(8'h10 + i)}};
    endfunction

    function automatic logic [127:0] textOf(input int i);
        return {16{8'(8'hc0 + i)}};
    endfunction

    int           latA = 3, latB = 3, cntA = 0, cntB = 0;
    bit           armA = 1'b1, armB = 1'b1;
    logic         doneA = 1'b0, doneB = 1'b0, strayA = 1'b0;
    logic [127:0] ctA = '0, ctB = '0;

    assign ifA.DONE = doneA | strayA;
    assign ifA.aes_ciphertext = ctA;
    assign ifB.DONE = doneB;
    assign ifB.aes_ciphertext = ctB;

    // DONE is raised at the negedge lat cycles after start is seen, so the
    // scheduler samples it lat+1 edges after start rose.
    always @(negedge HCLK) begin
        if (ifA.start) begin
            cntA = latA; doneA = 1'b0; ctA = coreModel(ifA.aes_key, ifA.aes_plaintext);
        end else if (cntA > 0) begin
            cntA = cntA - 1; doneA = armA && (cntA == 0);
        end else begin
            doneA = 1'b0;
        end
        if (ifB.start) begin
            cntB = latB; doneB = 1'b0; ctB = coreModel(ifB.aes_key, ifB.aes_plaintext);
        end else if (cntB > 0) begin
            cntB = cntB - 1; doneB = armB && (cntB == 0);
        end else begin
            doneB = 1'b0;
        end
    end

    task automatic setReq(input bit onB, input int idx, input logic [127:0] k, input logic [127:0] p);
        if (onB) begin
            ifB.req_key[128*idx +: 128] = k; ifB.req_text[128*idx +: 128] = p;
        end else begin
            ifA.req_key[128*idx +: 128] = k; ifA.req_text[128*idx +: 128] = p;
        end
    endtask

    // Submits one job and reports what was observed; the callers do the checking.
    task automatic runJob(input bit onB, input int idx, output int lat, output logic [3:0] rdy,
                          output logic [3:0] rsp, output logic [127:0] data, output logic err,
                          output int starts, output bit ok);
        bit started = 1'b0;
        int cyc = 0;
        logic [3:0] r, v;
        lat = -1; rdy = '0; rsp = '0; data = '0; err = 1'b0; starts = 0; ok = 1'b0;
        if (onB) ifB.req_valid[idx] = 1'b1; else ifA.req_valid[idx] = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge HCLK);
            if (started) cyc++;
            if (onB ? ifB.start : ifA.start) begin
                starts++;
                if (!started) begin started = 1'b1; cyc = 0; end
            end
            r = onB ? ifB.req_ready : ifA.req_ready;
            if (r != '0) begin
                rdy = r;
                if (onB) ifB.req_valid[idx] = 1'b0; else ifA.req_valid[idx] = 1'b0;
            end
            v = onB ? ifB.rsp_valid : ifA.rsp_valid;
            if (v != '0) begin
                rsp = v; lat = cyc; ok = 1'b1;
                data = onB ? ifB.rsp_data : ifA.rsp_data;
                err  = onB ? ifB.rsp_err : ifA.rsp_err;
                break;
            end
        end
    endtask

    task automatic test_reset();
        HRESETn = 1'b0;
        repeat (3) @(negedge HCLK);
        testsRun++; if (ifA.busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_busy: got %b expected 0", ifA.busy); end
        testsRun++; if (ifA.start !== 1'b0 || ifA.req_ready !== 4'b0) begin testsFailed++; $display("[TB] FAIL reset_start_ready: got %b/%b expected 0/0000", ifA.start, ifA.req_ready); end
        testsRun++; if (ifA.rsp_valid !== 4'b0 || ifA.rsp_err !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_rsp: got %b/%b expected 0000/0", ifA.rsp_valid, ifA.rsp_err); end
        testsRun++; if (ifA.rsp_data !== 128'h0) begin testsFailed++; $display("[TB] FAIL reset_rsp_data: got %h expected 0", ifA.rsp_data); end
        testsRun++; if (ifA.aes_key !== 128'h0 || ifA.aes_plaintext !== 128'h0) begin testsFailed++; $display("[TB] FAIL reset_operands: got %h/%h expected 0/0", ifA.aes_key, ifA.aes_plaintext); end
        testsRun++; if (ifB.busy !== 1'b0 || ifB.start !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_b: got busy %b start %b expected 0/0", ifB.busy, ifB.start); end
        HRESETn = 1'b1;
        @(negedge HCLK);
    endtask

    task automatic test_single_job();
        int lat, starts; logic [3:0] rdy, rsp; logic [127:0] data; logic err; bit ok;
        latA = 10; armA = 1'b1;
        setReq(1'b0, 0, K0, P0);
        runJob(1'b0, 0, lat, rdy, rsp, data, err, starts, ok);
        testsRun++; if (!ok) begin testsFailed++; $display("[TB] FAIL single_no_response: got none expected rsp_valid within 200 cycles"); end
        testsRun++; if (rdy !== 4'b0001) begin testsFailed++; $display("[TB] FAIL single_req_ready: got %b expected 0001", rdy); end
        testsRun++; if (rsp !== 4'b0001) begin testsFailed++; $display("[TB] FAIL single_rsp_valid: got %b expected 0001", rsp); end
        testsRun++; if (data !== C0) begin testsFailed++; $display("[TB] FAIL single_ciphertext: got %h expected %h", data, C0); end
        testsRun++; if (err !== 1'b0) begin testsFailed++; $display("[TB] FAIL single_err: got %b expected 0", err); end
        testsRun++; if (lat !== 11) begin testsFailed++; $display("[TB] FAIL single_latency: got %0d expected 11", lat); end
        testsRun++; if (starts !== 1) begin testsFailed++; $display("[TB] FAIL single_start_count: got %0d expected 1", starts); end
        @(negedge HCLK);
        testsRun++; if (ifA.busy !== 1'b0 || ifA.rsp_valid !== 4'b0) begin testsFailed++; $display("[TB] FAIL single_idle_after: got busy %b rsp %b expected 0/0000", ifA.busy, ifA.rsp_valid); end
    endtask

    task automatic test_round_robin();
        int order [5] = '{0, 1, 2, 3, 0};
        int readies = 0, rsps = 0, lastRsp = 0, cyc = 0;
        logic [3:0] r, v, expOh;
        logic [127:0] expData;
        latA = 3; armA = 1'b1;
        for (int i = 0; i < NREQ; i++) setReq(1'b0, i, keyOf(i), textOf(i));
        HRESETn = 1'b0;
        ifA.req_valid = 4'b1111;
        repeat (2) @(negedge HCLK);
        HRESETn = 1'b1;
        for (int n = 0; n < 400; n++) begin
            @(negedge HCLK);
            cyc++;
            r = ifA.req_ready;
            if (r != '0 && readies < 5) begin
                expOh = 4'(1) << order[readies];
                testsRun++; if (r !== expOh) begin testsFailed++; $display("[TB] FAIL rr_grant%0d: got %b expected %b", readies, r, expOh); end
                if (rsps > 0) begin
                    testsRun++; if (cyc - lastRsp !== 2) begin testsFailed++; $display("[TB] FAIL rr_gap%0d: got %0d expected 2", readies, cyc - lastRsp); end
                end
                readies++;
            end
            v = ifA.rsp_valid;
            if (v != '0) begin
                expOh   = 4'(1) << order[rsps];
                expData = keyOf(order[rsps]) ^ textOf(order[rsps]);
                testsRun++; if (v !== expOh) begin testsFailed++; $display("[TB] FAIL rr_rsp%0d: got %b expected %b", rsps, v, expOh); end
                testsRun++; if (ifA.rsp_data !== expData || ifA.rsp_err !== 1'b0) begin testsFailed++; $display("[TB] FAIL rr_data%0d: got %h err %b expected %h err 0", rsps, ifA.rsp_data, ifA.rsp_err, expData); end
                lastRsp = cyc;
                rsps++;
                if (rsps == 5) begin ifA.req_valid = 4'b0000; break; end
            end
        end
        testsRun++; if (rsps !== 5) begin testsFailed++; $display("[TB] FAIL rr_job_count: got %0d expected 5", rsps); end
        repeat (2) @(negedge HCLK);
        testsRun++; if (ifA.busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL rr_idle_after: got %b expected 0", ifA.busy); end
    endtask

    task automatic test_done_timeout_tie();
        int lat, starts; logic [3:0] rdy, rsp; logic [127:0] data; logic err; bit ok;
        latB = 8; armB = 1'b1;
        setReq(1'b1, 0, keyOf(0), textOf(0));
        runJob(1'b1, 0, lat, rdy, rsp, data, err, starts, ok);
        testsRun++; if (!ok || rsp !== 4'b0001) begin testsFailed++; $display("[TB] FAIL tie_rsp_valid: got %b expected 0001", rsp); end
        testsRun++; if (err !== 1'b0) begin testsFailed++; $display("[TB] FAIL tie_err: got %b expected 0", err); end
        testsRun++; if (data !== (keyOf(0) ^ textOf(0))) begin testsFailed++; $display("[TB] FAIL tie_data: got %h expected %h", data, keyOf(0) ^ textOf(0)); end
        testsRun++; if (lat !== 9) begin testsFailed++; $display("[TB] FAIL tie_latency: got %0d expected 9", lat); end
        @(negedge HCLK);
    endtask

    task automatic test_timeout();
        int lat, starts; logic [3:0] rdy, rsp; logic [127:0] data; logic err; bit ok;
        armB = 1'b0;
        setReq(1'b1, 2, keyOf(2), textOf(2));
        runJob(1'b1, 2, lat, rdy, rsp, data, err, starts, ok);
        testsRun++; if (!ok || rsp !== 4'b0100) begin testsFailed++; $display("[TB] FAIL to_rsp_valid: got %b expected 0100", rsp); end
        testsRun++; if (err !== 1'b1) begin testsFailed++; $display("[TB] FAIL to_err: got %b expected 1", err); end
        testsRun++; if (data !== 128'h0) begin testsFailed++; $display("[TB] FAIL to_data: got %h expected 0", data); end
        testsRun++; if (lat !== 9) begin testsFailed++; $display("[TB] FAIL to_latency: got %0d expected 9", lat); end
        @(negedge HCLK);
        testsRun++; if (ifB.busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL to_idle_after: got %b expected 0", ifB.busy); end
        armB = 1'b1; latB = 3;
        setReq(1'b1, 1, keyOf(1), textOf(1));
        runJob(1'b1, 1, lat, rdy, rsp, data, err, starts, ok);
        testsRun++; if (!ok || rsp !== 4'b0010 || err !== 1'b0) begin testsFailed++; $display("[TB] FAIL to_next_job: got rsp %b err %b expected 0010 err 0", rsp, err); end
        testsRun++; if (data !== (keyOf(1) ^ textOf(1)) || lat !== 4) begin testsFailed++; $display("[TB] FAIL to_next_data: got %h lat %0d expected %h lat 4", data, lat, keyOf(1) ^ textOf(1)); end
        @(negedge HCLK);
    endtask

    task automatic test_stray_and_reset();
        int lat, starts; logic [3:0] rdy, rsp; logic [127:0] data; logic err; bit ok;
        bit sawActivity = 1'b0, granted = 1'b0;
        int rsps = 0;
        logic [3:0] firstGrant = '0, secondGrant = '0;
        strayA = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(negedge HCLK);
            if (ifA.rsp_valid != '0 || ifA.busy || ifA.start) sawActivity = 1'b1;
        end
        strayA = 1'b0;
        @(negedge HCLK);
        testsRun++; if (sawActivity !== 1'b0 || ifA.rsp_valid !== 4'b0) begin testsFailed++; $display("[TB] FAIL stray_done: got activity %b expected 0", sawActivity); end
        latA = 3; armA = 1'b1;
        setReq(1'b0, 2, keyOf(2), textOf(2));
        setReq(1'b0, 3, keyOf(3), textOf(3));
        runJob(1'b0, 2, lat, rdy, rsp, data, err, starts, ok);
        testsRun++; if (!ok || rsp !== 4'b0100) begin testsFailed++; $display("[TB] FAIL pre_reset_job: got %b expected 0100", rsp); end
        @(negedge HCLK);
        armA = 1'b0;
        ifA.req_valid[3] = 1'b1;
        for (int n = 0; n < 20 && !granted; n++) begin
            @(negedge HCLK);
            if (ifA.req_ready[3]) begin granted = 1'b1; ifA.req_valid[3] = 1'b0; end
        end
        testsRun++; if (!granted) begin testsFailed++; $display("[TB] FAIL abort_job_grant: got none expected req_ready[3]"); end
        repeat (3) @(negedge HCLK);
        HRESETn = 1'b0;
        #1;
        testsRun++; if (ifA.busy !== 1'b0 || ifA.rsp_valid !== 4'b0 || ifA.rsp_err !== 1'b0) begin testsFailed++; $display("[TB] FAIL midjob_reset_ctrl: got busy %b rsp %b err %b expected 0", ifA.busy, ifA.rsp_valid, ifA.rsp_err); end
        testsRun++; if (ifA.rsp_data !== 128'h0 || ifA.aes_key !== 128'h0 || ifA.aes_plaintext !== 128'h0) begin testsFailed++; $display("[TB] FAIL midjob_reset_data: got %h/%h/%h expected 0", ifA.rsp_data, ifA.aes_key, ifA.aes_plaintext); end
        testsRun++; if (ifA.start !== 1'b0 || ifA.req_ready !== 4'b0) begin testsFailed++; $display("[TB] FAIL midjob_reset_pulses: got %b/%b expected 0/0000", ifA.start, ifA.req_ready); end
        repeat (2) @(negedge HCLK);
        armA = 1'b1; latA = 3;
        HRESETn = 1'b1;
        ifA.req_valid = 4'b1100;
        for (int n = 0; n < 100; n++) begin
            @(negedge HCLK);
            if (ifA.req_ready != '0) begin
                if (firstGrant == '0) firstGrant = ifA.req_ready; else secondGrant = ifA.req_ready;
                ifA.req_valid = ifA.req_valid & ~ifA.req_ready;
            end
            if (ifA.rsp_valid != '0) rsps++;
            if (rsps == 2) break;
        end
        testsRun++; if (firstGrant !== 4'b0100) begin testsFailed++; $display("[TB] FAIL post_reset_first_grant: got %b expected 0100", firstGrant); end
        testsRun++; if (secondGrant !== 4'b1000 || rsps !== 2) begin testsFailed++; $display("[TB] FAIL post_reset_second_grant: got %b rsps %0d expected 1000 rsps 2", secondGrant, rsps); end
        ifA.req_valid = '0;
        @(negedge HCLK);
    endtask

    initial begin
        HRESETn       = 1'b0;
        ifA.req_valid = '0; ifA.req_key = '0; ifA.req_text = '0;
        ifB.req_valid = '0; ifB.req_key = '0; ifB.req_text = '0;
        test_reset();
        test_single_job();
        test_round_robin();
        test_done_timeout_tie();
        test_timeout();
        test_stray_and_reset();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
